// File: rtl/cond_unit_pkg.sv
// Shared constants for the conditional-execution stage: ARM condition codes
// and the bit positions of N, Z, C, V inside the status register.
package cond_unit_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_unit_cond_check.sv
// Combinational condition evaluator: decides whether the instruction's
// condition field passes against the current NZCV register.
import cond_unit_pkg::*;

module cond_check (
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  always_comb begin
    // NOTE: default assigned before the case so every path drives CondEx and no latch is inferred.
    CondEx = 1'b1;
    case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = (n == v);
      COND_LT: CondEx = (n != v);
      COND_GT: CondEx = ~z & (n == v);
      COND_LE: CondEx = z | (n != v);
      default: CondEx = 1'b1;  // AL and 4'b1111 both execute unconditionally
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution stage of the multicycle ARM controller: NZCV register,
// condition gating of write strobes. Optional squash counter under COND_STATS_EN.
import cond_unit_pkg::*;

module cond_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             NextPC,
  input  logic             Branch,
  input  logic             RegW,
  input  logic             MemW,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] SquashCount
);

  logic       CondEx;
  logic       CondExDelayed;
  logic [1:0] FlagWrite;

  cond_check u_cond_check (
    .Cond   (Cond),
    .Flags  (Flags),
    .CondEx (CondEx)
  );

  // Flag-setting instructions are judged against the pre-update flags.
  assign FlagWrite = FlagW & {2{CondEx}};

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      Flags         <= 4'b0000;
      CondExDelayed <= 1'b0;
    end else begin
      if (FlagWrite[1]) Flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      if (FlagWrite[0]) Flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
      CondExDelayed <= CondEx;
    end
  end

  // Later states of an instruction use the condition evaluated at decode.
  assign PCWrite  = NextPC | (Branch & CondExDelayed);
  assign RegWrite = RegW & CondExDelayed;
  assign MemWrite = MemW & CondExDelayed;

`ifdef COND_STATS_EN
  logic [CNT_W-1:0] squash_cnt;
  logic             squash;

  assign squash = (RegW | MemW | Branch) & ~CondExDelayed;

  always_ff @(posedge clk) begin
    if (reset) begin
      squash_cnt <= '0;
    end else if (squash && (squash_cnt != '1)) begin
      squash_cnt <= squash_cnt + CNT_W'(1);
    end
  end

  assign SquashCount = squash_cnt;
`else
  assign SquashCount = '0;
`endif

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Conditional-execution stage of the multicycle ARM controller. Consumes the main FSM's raw strobes (NextPC, Branch, RegW, MemW) and the ALU decoder's FlagW.
- Holds the NZCV status register and evaluates the instruction condition field.
- Produces the gated architectural write enables (PCWrite, RegWrite, MemWrite) used by the datapath.

Parameters:
- CNT_W, 16, width of the squash counter (used only with COND_STATS_EN).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- Cond  in  4  Instr[31:28] of the instruction currently in IR
- ALUFlags  in  4  {N,Z,C,V} from the ALU in the current cycle
- FlagW  in  2  [1] update N,Z; [0] update C,V (from ALU decoder, execute states only)
- NextPC  in  1  unconditional PC write (fetch)
- Branch  in  1  branch state strobe
- RegW  in  1  register-writeback strobe
- MemW  in  1  memory-write strobe
- PCWrite  out  1  gated PC enable
- RegWrite  out  1  gated register-file write enable
- MemWrite  out  1  gated memory write enable
- Flags  out  4  current {N,Z,C,V} register
- SquashCount  out  CNT_W  squashed-instruction count (tied 0 when feature is off)

Behaviour:
- Reset, synchronous, highest priority:
  - Flags=4'b0000, CondExDelayed=0.
  - Therefore RegWrite=MemWrite=0, and PCWrite=NextPC.
- CondEx is combinational from Cond and the Flags register, with {N,Z,C,V}=Flags:
  - EQ 0000: Z; NE 0001: ~Z; CS 0010: C; CC 0011: ~C
  - MI 0100: N; PL 0101: ~N; VS 0110: V; VC 0111: ~V
  - HI 1000: C&~Z; LS 1001: ~C|Z
  - GE 1010: N==V; LT 1011: N!=V
  - GT 1100: ~Z&(N==V); LE 1101: Z|(N!=V)
  - AL 1110: 1; 1111: 1 (treated as unconditional)
- FlagWrite = FlagW & {2{CondEx}}, combinational, same cycle.
  - On the clock edge: if FlagWrite[1], N,Z <= ALUFlags[3:2]; if FlagWrite[0], C,V <= ALUFlags[1:0]. Halves are independent.
- CondExDelayed <= CondEx on every non-reset edge. It is the condition result from the previous cycle.
  - Since the DECODE state always precedes execute/writeback, all later states of an instruction see the condition evaluated against the flags present at decode.
- Outputs, all combinational, no added latency:
  - PCWrite = NextPC | (Branch & CondExDelayed)
  - RegWrite = RegW & CondExDelayed
  - MemWrite = MemW & CondExDelayed
- Flag update vs. condition: an instruction that sets flags in cycle t uses CondEx computed from the pre-update flags. The new flags are visible from cycle t+1.
- Boundary cases:
  - FlagW asserted with CondEx=0: no flag change.
  - NextPC and Branch both high: PCWrite=1.
  - Reset asserted mid-instruction: any pending write is suppressed in the following cycle because CondExDelayed=0.
  - Unknown Cond is impossible; all 16 codes are defined.

Optional Feature:
- Macro COND_STATS_EN.
- Defined:
  - CNT_W-bit counter increments on each edge where (RegW|MemW|Branch) & ~CondExDelayed. Each instruction asserts at most one of these strobes, and for exactly one cycle.
  - Saturates at all-ones; cleared by reset; drives SquashCount.
- Undefined: no counter logic; SquashCount driven constant 0.

Decomposition:
- Shared package:
  - 4-bit condition-code constants (COND_EQ ... COND_AL).
  - Flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
- One sub-module, cond_check: purely combinational, (Cond, Flags) -> CondEx, instantiated once.

Test Plan:
- Reset: hold reset 2 cycles with NextPC=1, RegW=1 -> Flags=0000, PCWrite=1, RegWrite=0; the cycle after reset deassert, still RegWrite=0.
- Flag update: Cond=1110, FlagW=11, ALUFlags=0100 -> next cycle Flags=0100. Then FlagW=01, ALUFlags=1011 -> Flags=0111.
- EQ taken/not taken:
  - Flags Z=1, Cond=0000, one cycle later Branch=1 -> PCWrite=1.
  - Same sequence with Z=0 -> PCWrite=0, and SquashCount increments by 1 when the feature is on.
- Conditional store: Flags=1000 (N=1,V=0), Cond=1011 (LT), MemW asserted two cycles later -> MemWrite=1. Cond=1010 (GE) -> MemWrite=0.
- Same-cycle ordering: Flags=0000, Cond=0000, FlagW=11, ALUFlags=0100 -> flags unchanged (CondEx=0). With Cond=1110, Flags become 0100 and a following Cond=0000 instruction executes.
- Saturation (COND_STATS_EN, CNT_W=4): 20 squashed RegW pulses -> SquashCount=4'hF.
